// File: rtl/rom_loader.sv
// rom_loader: receives a framed byte stream and writes it into instruction
// memory while holding the CPU in reset until the image is complete.
//
// Frame: 8'hA5, count[15:8], count[7:0], then count words sent high byte first,
// then (checksum build only) one byte equal to the mod-256 sum of the data bytes.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   rx_valid   source has a byte on rx_data
//   rx_data    incoming byte
//   rx_ready   loader accepts a byte (transfer on rx_valid && rx_ready)
//   rom_we     one-cycle instruction-memory write strobe
//   rom_addr   write address, BASE_ADDR + word index (wraps mod 2^16)
//   rom_wdata  write data
//   cpu_rst    high until a load completes
//   busy       load in progress
//   done       image loaded successfully
//   error      load aborted
//
// Build option: define ROM_LOADER_CHECKSUM_EN to add the trailing checksum
// byte and the CHECK state; without it the loader finishes after the last word.
module rom_loader #(
  parameter logic [15:0]  BASE_ADDR = 16'h0000,
  parameter int unsigned  MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        rom_we,
  output logic [15:0] rom_addr,
  output logic [15:0] rom_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [15:0] count;
  logic [15:0] index;
  logic [7:0]  hi_byte;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  logic        accept;
  logic [15:0] len_word;
  logic        len_ok;
  logic [15:0] index_nxt;

  assign accept    = rx_valid && rx_ready;
  // Full count as it will be after the LEN_LO byte is captured.
  assign len_word  = {count[15:8], rx_data};
  assign len_ok    = (len_word != 16'd0) && (32'(len_word) <= MAX_WORDS);
  assign index_nxt = index + 16'd1;

  // Status flags are pure decodes of the state register.
`ifdef ROM_LOADER_CHECKSUM_EN
  assign rx_ready = (state inside {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK});
  assign busy     = (state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK});
`else
  assign rx_ready = (state inside {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO});
  assign busy     = (state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE});
`endif
  assign cpu_rst  = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);

  // Loader FSM; rom_we is high only while the state register holds WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 16'd0;
      index     <= 16'd0;
      hi_byte   <= 8'd0;
      rom_we    <= 1'b0;
      rom_addr  <= BASE_ADDR;
      rom_wdata <= 16'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum       <= 8'd0;
`endif
    end else begin
      rom_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && rx_data == SYNC_BYTE) begin
            state <= LEN_HI;
            index <= 16'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum   <= 8'd0;
`endif
          end
        end
        LEN_HI: begin
          if (accept) begin
            count[15:8] <= rx_data;
            state       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            count[7:0] <= rx_data;
            state      <= len_ok ? DATA_HI : ERR;
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_byte <= rx_data;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum     <= sum + rx_data;
`endif
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            rom_we    <= 1'b1;
            rom_addr  <= BASE_ADDR + index;
            rom_wdata <= {hi_byte, rx_data};
`ifdef ROM_LOADER_CHECKSUM_EN
            sum       <= sum + rx_data;
`endif
            state     <= WRITE;
          end
        end
        WRITE: begin
          index <= index_nxt;
          if (index_nxt == count) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state <= DONE;
`endif
          end else begin
            state <= DATA_HI;
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) state <= (rx_data == sum) ? DONE : ERR;
        end
`endif
        DONE:    state <= DONE;
        ERR:     state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader. Two instances: dut0 (BASE_ADDR 0, MAX_WORDS 4)
// and dut1 (BASE_ADDR FFFF, default MAX_WORDS); sel chooses which one is driven
// and observed. Expected writes are queued as words are sent and popped when
// rom_we is seen. Honours ROM_LOADER_CHECKSUM_EN for the trailing byte.
module tb_rom_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        sel;

  logic        rdy0, we0, cpu0, busy0, done0, err0;
  logic [15:0] addr0, wd0;
  logic        rdy1, we1, cpu1, busy1, done1, err1;
  logic [15:0] addr1, wd1;

  logic        cur_ready, cur_we, cur_cpu, cur_busy, cur_done, cur_err;
  logic [15:0] cur_addr, cur_wd;

  wr_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic        prev_we = 1'b0;
  logic [7:0]  csum;

  always #5 clk = ~clk;

  rom_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(4)) dut0 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid && !sel), .rx_data(rx_data),
    .rx_ready(rdy0), .rom_we(we0), .rom_addr(addr0), .rom_wdata(wd0),
    .cpu_rst(cpu0), .busy(busy0), .done(done0), .error(err0)
  );

  rom_loader #(.BASE_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid && sel), .rx_data(rx_data),
    .rx_ready(rdy1), .rom_we(we1), .rom_addr(addr1), .rom_wdata(wd1),
    .cpu_rst(cpu1), .busy(busy1), .done(done1), .error(err1)
  );

  assign cur_ready = sel ? rdy1  : rdy0;
  assign cur_we    = sel ? we1   : we0;
  assign cur_addr  = sel ? addr1 : addr0;
  assign cur_wd    = sel ? wd1   : wd0;
  assign cur_cpu   = sel ? cpu1  : cpu0;
  assign cur_busy  = sel ? busy1 : busy0;
  assign cur_done  = sel ? done1 : done0;
  assign cur_err   = sel ? err1  : err0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge, writes scored against the queue.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    @(negedge clk);
    if (cur_we === 1'b1) begin
      pulses++;
      check("we_one_cycle", 32'(prev_we), 32'd0);
      check("we_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        check("wr_addr", 32'(cur_addr), 32'(w.addr));
        check("wr_data", 32'(cur_wd), 32'(w.data));
      end
    end
    prev_we = cur_we;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (cur_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(cur_ready), 32'd1);
    else tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] addr, input logic [15:0] data);
    sb.push_back('{addr: addr, data: data});
    csum = csum + data[15:8] + data[7:0];
    send_byte(data[15:8]);
    send_byte(data[7:0]);
  endtask

  task automatic send_header(input logic [15:0] len);
    csum = 8'd0;
    send_byte(8'hA5);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
  endtask

  task automatic stall_rand();
    rx_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) break;
      tick();
    end
  endtask

  task automatic wait_end();
    for (int i = 0; i < 20; i++) begin
      if (cur_done === 1'b1 || cur_err === 1'b1) break;
      tick();
    end
  endtask

  task automatic check_reset(input string tag, input logic [15:0] base);
    check({tag, "_ready"}, 32'(cur_ready), 32'd1);
    check({tag, "_we"},    32'(cur_we),    32'd0);
    check({tag, "_addr"},  32'(cur_addr),  32'(base));
    check({tag, "_wdata"}, 32'(cur_wd),    32'd0);
    check({tag, "_cpu"},   32'(cur_cpu),   32'd1);
    check({tag, "_busy"},  32'(cur_busy),  32'd0);
    check({tag, "_done"},  32'(cur_done),  32'd0);
    check({tag, "_err"},   32'(cur_err),   32'd0);
  endtask

  task automatic do_reset(input string tag, input logic [15:0] base);
    rst = 1'b1;
    tick();
    check_reset(tag, base);
    rst = 1'b0;
    pulses = 0;
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    sel      = 1'b0;
    csum     = 8'd0;
    tick();
    do_reset("rst0", 16'h0000);
    check("rst0_dut1_addr", 32'(addr1), 32'h0000FFFF);

    // Nominal two-word image with a discarded leading byte.
    send_byte(8'h00);
    check("idle_discard_busy", 32'(cur_busy), 32'd0);
    send_byte(8'hA5);
    check("sync_busy", 32'(cur_busy), 32'd1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(16'h0000, 16'h1234);
    send_word(16'h0001, 16'hABCD);
`ifdef ROM_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    wait_end();
    check("nom_done",   32'(cur_done),  32'd1);
    check("nom_cpu",    32'(cur_cpu),   32'd0);
    check("nom_err",    32'(cur_err),   32'd0);
    check("nom_busy",   32'(cur_busy),  32'd0);
    check("nom_ready",  32'(cur_ready), 32'd0);
    check("nom_pulses", 32'(pulses),    32'd2);
    check("nom_hold_addr", 32'(cur_addr), 32'h0001);
    check("nom_hold_data", 32'(cur_wd),   32'hABCD);
    tick();
    check("nom_terminal", 32'(cur_done), 32'd1);

`ifdef ROM_LOADER_CHECKSUM_EN
    // Bad checksum: both words written, then abort.
    do_reset("rst_ck", 16'h0000);
    send_header(16'd2);
    send_word(16'h0000, 16'h1234);
    send_word(16'h0001, 16'hABCD);
    send_byte(8'h00);
    wait_end();
    check("ck_err",    32'(cur_err),   32'd1);
    check("ck_cpu",    32'(cur_cpu),   32'd1);
    check("ck_ready",  32'(cur_ready), 32'd0);
    check("ck_pulses", 32'(pulses),    32'd2);
`endif

    // Zero-length image.
    do_reset("rst_z", 16'h0000);
    send_header(16'd0);
    wait_end();
    check("zero_err",    32'(cur_err),   32'd1);
    check("zero_cpu",    32'(cur_cpu),   32'd1);
    check("zero_ready",  32'(cur_ready), 32'd0);
    check("zero_done",   32'(cur_done),  32'd0);
    check("zero_pulses", 32'(pulses),    32'd0);

    // Length exactly MAX_WORDS is accepted, one over is rejected.
    do_reset("rst_m4", 16'h0000);
    send_header(16'd4);
    check("max_busy", 32'(cur_busy), 32'd1);
    check("max_err",  32'(cur_err),  32'd0);
    do_reset("rst_m5", 16'h0000);
    send_header(16'd5);
    wait_end();
    check("over_err",    32'(cur_err), 32'd1);
    check("over_pulses", 32'(pulses),  32'd0);

    // Three-word load with random valid stalls.
    do_reset("rst_st", 16'h0000);
    stall_rand();
    send_header(16'd3);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      stall_rand();
      sb.push_back('{addr: 16'(i), data: d});
      csum = csum + d[15:8] + d[7:0];
      send_byte(d[15:8]);
      stall_rand();
      send_byte(d[7:0]);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    stall_rand();
    send_byte(csum);
`endif
    wait_end();
    check("stall_done",   32'(cur_done), 32'd1);
    check("stall_pulses", 32'(pulses),   32'd3);

    // Reset right after the first word's write, then a fresh load.
    do_reset("rst_mid0", 16'h0000);
    send_header(16'd2);
    send_word(16'h0000, 16'h5555);
    check("mid_we_seen", 32'(pulses), 32'd1);
    do_reset("rst_mid", 16'h0000);
    send_header(16'd1);
    send_word(16'h0000, 16'h5A5A);
`ifdef ROM_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    wait_end();
    check("fresh_done",   32'(cur_done), 32'd1);
    check("fresh_pulses", 32'(pulses),   32'd1);

    // Address wrap from FFFF to 0000.
    sel = 1'b1;
    do_reset("rst_wrap", 16'hFFFF);
    send_header(16'd2);
    send_word(16'hFFFF, 16'h1111);
    send_word(16'h0000, 16'h2222);
`ifdef ROM_LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    wait_end();
    check("wrap_done",   32'(cur_done), 32'd1);
    check("wrap_err",    32'(cur_err),  32'd0);
    check("wrap_pulses", 32'(pulses),   32'd2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
